// File: rtl/prefetch_issue_queue_if.sv
// prefetch_issue_queue_if: candidate capture and memory request bundle.
// slave faces the queue, master faces prefetcher/memory side.
interface prefetch_issue_queue_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] in_addr;
  logic              in_valid;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;

  modport slave (
    input  in_addr,
    input  in_valid,
    input  mem_gnt,
    output mem_req,
    output mem_addr
  );

  modport master (
    output in_addr,
    output in_valid,
    output mem_gnt,
    input  mem_req,
    input  mem_addr
  );
endinterface

// File: rtl/prefetch_issue_queue.sv
// prefetch_issue_queue: filters, buffers and issues prefetch candidates.
// Optional macro PFQ_HISTORY_EN adds a recently-granted address history.
module prefetch_issue_queue #(
  parameter  int ADDR_W     = 32,
  parameter  int DEPTH      = 8,
  parameter  int GRID_CELLS = 27,
  parameter  int HIST       = 4,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  prefetch_issue_queue_if.slave bus,
  output logic [CW-1:0]        occupancy,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          filt_cnt
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] qmem [DEPTH];
  logic [PW-1:0]     head, tail, off;
  logic              empty, full, pop, push;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;
  logic              oor, dup_q, dup_f, dup_h, dup;

  assign empty = (occupancy == '0);
  assign full  = (occupancy == CW'(DEPTH));
  assign oor   = bus.in_addr >= ADDR_W'(GRID_CELLS);
  assign dup_f = bus.mem_req && (bus.mem_addr == bus.in_addr);
  assign dup   = dup_q || dup_f || dup_h;
  assign push  = bus.in_valid && !oor && !dup && !(full && !pop);

  // Match candidate against every live queue slot.
  always_comb begin
    dup_q = 1'b0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if (({1'b0, off} < occupancy) && (qmem[i] == bus.in_addr))
        dup_q = 1'b1;
    end
  end

`ifdef PFQ_HISTORY_EN
  localparam int HPW = (HIST > 1) ? $clog2(HIST) : 1;

  logic [ADDR_W-1:0] hist [HIST];
  logic [HIST-1:0]   hist_vld;
  logic [HPW-1:0]    hist_ptr;

  // Match candidate against recently granted addresses.
  always_comb begin
    dup_h = 1'b0;
    for (int i = 0; i < HIST; i++)
      if (hist_vld[i] && (hist[i] == bus.in_addr))
        dup_h = 1'b1;
  end

  // Record each granted address round-robin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_vld <= '0;
      hist_ptr <= '0;
    end else if (bus.mem_req && bus.mem_gnt) begin
      hist[hist_ptr]     <= bus.mem_addr;
      hist_vld[hist_ptr] <= 1'b1;
      hist_ptr <= (hist_ptr == HPW'(HIST - 1)) ? '0 : hist_ptr + 1'b1;
    end
  end
`else
  logic unused_hist;
  assign unused_hist = (HIST != 0);
  assign dup_h = 1'b0;
`endif

  // Issue FSM: pop into the request register when free or on grant.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    req_d   = bus.mem_req;
    addr_d  = bus.mem_addr;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          req_d   = 1'b1;
          addr_d  = qmem[head];
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          if (!empty) begin
            pop    = 1'b1;
            addr_d = qmem[head];
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request register, pointers, occupancy and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      head         <= '0;
      tail         <= '0;
      occupancy    <= '0;
      drop_cnt     <= '0;
      filt_cnt     <= '0;
    end else begin
      state        <= state_d;
      bus.mem_req  <= req_d;
      bus.mem_addr <= addr_d;
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      occupancy <= occupancy + CW'(push) - CW'(pop);
      if (bus.in_valid && (oor || dup) && (filt_cnt != 16'hFFFF))
        filt_cnt <= filt_cnt + 1'b1;
      if (bus.in_valid && !oor && !dup && full && !pop &&
          (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Queue storage; no reset needed, liveness comes from occupancy.
  always_ff @(posedge clock) begin
    if (push) qmem[tail] <= bus.in_addr;
  end
endmodule

// File: tb/tb_prefetch_issue_queue.sv
// tb_prefetch_issue_queue: directed stimulus with a grant-side scoreboard.
// Expected issue order is queued at stimulus time and checked per grant.
module tb_prefetch_issue_queue;
  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  logic [3:0]  occupancy;
  logic [15:0] drop_cnt;
  logic [15:0] filt_cnt;

  int checks = 0;
  int errors = 0;
  int exp_filt = 0;
  logic [31:0] exp_q [$];

  prefetch_issue_queue_if #(.ADDR_W(32)) bus ();

  prefetch_issue_queue #(
    .ADDR_W(32), .DEPTH(DEPTH), .GRID_CELLS(27), .HIST(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave),
    .occupancy(occupancy),
    .drop_cnt(drop_cnt),
    .filt_cnt(filt_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [31:0] a);
    bus.in_addr  = a;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((bus.mem_req || occupancy != 0) && n < 40) begin
      step();
      n++;
    end
    chk({name, "_req_done"}, {31'd0, bus.mem_req}, 32'd0);
    chk({name, "_occ_done"}, {28'd0, occupancy}, 32'd0);
  endtask

  // Scoreboard monitor: every grant must match the next expected address.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (!reset && bus.mem_req && bus.mem_gnt) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected got %0d required none",
                   bus.mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.mem_addr !== e) begin
            errors++;
            $display("FAIL grant_order got %0d required %0d",
                     bus.mem_addr, e);
          end
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.in_addr  = '0;
    bus.in_valid = 1'b0;
    bus.mem_gnt  = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_occ", {28'd0, occupancy}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_filt", {16'd0, filt_cnt}, 32'd0);
    reset = 1'b0;
    step();

    // single candidate, one cycle of latency, granted at once
    bus.mem_gnt = 1'b1;
    exp_q.push_back(32'd13);
    send(32'd13);
    chk("t1_req_e0", {31'd0, bus.mem_req}, 32'd0);
    chk("t1_occ_e0", {28'd0, occupancy}, 32'd1);
    step();
    chk("t1_req_e1", {31'd0, bus.mem_req}, 32'd1);
    chk("t1_addr_e1", bus.mem_addr, 32'd13);
    chk("t1_occ_e1", {28'd0, occupancy}, 32'd0);
    step();
    chk("t1_req_e2", {31'd0, bus.mem_req}, 32'd0);
    chk("t1_filt", {16'd0, filt_cnt}, 32'd0);
    chk("t1_drop", {16'd0, drop_cnt}, 32'd0);

    // out-of-range candidates, including the GRID_CELLS boundary
    send(32'd27);
    send(32'd40);
    exp_filt = 2;
    step();
    step();
    chk("t2_req", {31'd0, bus.mem_req}, 32'd0);
    chk("t2_filt", {16'd0, filt_cnt}, exp_filt);

    // burst with a duplicate of the in-flight address
    bus.mem_gnt = 1'b0;
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd14);
    send(32'd4);
    send(32'd12);
    send(32'd4);
    send(32'd14);
    exp_filt = exp_filt + 1;
    chk("t3_occ", {28'd0, occupancy}, 32'd2);
    chk("t3_req", {31'd0, bus.mem_req}, 32'd1);
    chk("t3_addr", bus.mem_addr, 32'd4);
    chk("t3_filt", {16'd0, filt_cnt}, exp_filt);
    bus.mem_gnt = 1'b1;
    drain("t3");

    // re-send an address that was already granted
`ifdef PFQ_HISTORY_EN
    send(32'd13);
    exp_filt = exp_filt + 1;
    step();
    chk("t4_req", {31'd0, bus.mem_req}, 32'd0);
`else
    exp_q.push_back(32'd13);
    send(32'd13);
    step();
    chk("t4_req", {31'd0, bus.mem_req}, 32'd1);
    chk("t4_addr", bus.mem_addr, 32'd13);
    drain("t4");
`endif
    chk("t4_filt", {16'd0, filt_cnt}, exp_filt);

    // overfill: one in flight, DEPTH queued, last one dropped
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH + 1) exp_q.push_back(32'd16 + 32'(i));
      send(32'd16 + 32'(i));
    end
    chk("t5_occ", {28'd0, occupancy}, 32'(DEPTH));
    chk("t5_drop", {16'd0, drop_cnt}, 32'd1);
    chk("t5_addr", bus.mem_addr, 32'd16);
    chk("t5_filt", {16'd0, filt_cnt}, exp_filt);

    // full queue, grant and new candidate on the same edge
    bus.mem_gnt = 1'b1;
    exp_q.push_back(32'd26);
    send(32'd26);
    chk("t6_occ", {28'd0, occupancy}, 32'(DEPTH));
    chk("t6_drop", {16'd0, drop_cnt}, 32'd1);
    chk("t6_addr", bus.mem_addr, 32'd17);
    drain("t6");

    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_empty got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prefetch_issue_queue.md
# prefetch_issue_queue

Downstream stage of the 3D grid prefetcher. Captures each candidate address the prefetcher emits on its one-cycle `ready` strobe, discards out-of-grid and redundant candidates, buffers the rest in order, and issues them one at a time to the memory request port with a req/gnt handshake. The prefetcher has no backpressure, so this block absorbs bursts and drops on overflow, with saturating counters recording every discard.

## Interface
- `ADDR_W`, 32: address width.
- `DEPTH`, 8: queue entries; power of two, ≥ 2.
- `GRID_CELLS`, 27: valid addresses are 0 .. GRID_CELLS-1.
- `HIST`, 4: recently-granted history entries (used only with PFQ_HISTORY_EN).
- `clock`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `in_addr`  in  ADDR_W  candidate address from the prefetcher.
- `in_valid`  in  1  candidate strobe; sampled every rising edge.
- `mem_req`  out  1  request valid; registered.
- `mem_addr`  out  ADDR_W  request address; registered, stable while `mem_req`=1.
- `mem_gnt`  in  1  memory accepts the request on an edge where `mem_req`=`mem_gnt`=1.
- `occupancy`  out  $clog2(DEPTH)+1  queued entries; excludes the in-flight request.
- `drop_cnt`  out  16  candidates lost because the queue was full; saturating.
- `filt_cnt`  out  16  candidates discarded as out-of-range or duplicate; saturating.

## Operation
- Reset values: `mem_req`=0, `mem_addr`=0, `occupancy`=0, `drop_cnt`=0, `filt_cnt`=0. Queue pointers are cleared, and history valid bits are cleared when the history is compiled in.
- Each edge with `in_valid`=1, classify the candidate in priority order:
  1. `in_addr` ≥ GRID_CELLS: discard, `filt_cnt`+1.
  2. Duplicate: discard, `filt_cnt`+1. A candidate is a duplicate if it matches any valid queue entry (including one popped on the same edge), matches `mem_addr` while `mem_req`=1 (including on the grant edge), or matches a valid history entry.
  3. Queue full after accounting for a same-edge pop: discard, `drop_cnt`+1.
  4. Otherwise push to the tail.
- Counters saturate at 0xFFFF. A single candidate increments exactly one counter, or none if it is pushed.
- FSM states:
  - IDLE: `mem_req`=0. On an edge with the queue non-empty, pop the head into `mem_addr`, set `mem_req`=1, and go to REQ.
  - REQ: hold `mem_req` and `mem_addr`. On the grant edge:
    - queue non-empty: pop the next head into `mem_addr`, keep `mem_req`=1, stay in REQ (back-to-back issue).
    - queue empty: `mem_req`←0, go to IDLE.
- Issue order is strictly FIFO in push order.
- Queue pointers wrap modulo DEPTH. Full/empty are decided by `occupancy`, not by pointer equality alone.
- Reset asserted mid-operation: an in-flight request is abandoned; there is no retry after reset.

## Timing
- Capture to request: `in_valid` at edge E0 → entry queued after E0. If the FSM is IDLE, it pops at E1, so `mem_req`=1 from E1 (one cycle of latency through an empty block).
- Throughput: one request per cycle when `mem_gnt` is held high and the queue is non-empty.
- `mem_gnt` is ignored while `mem_req`=0.
- `occupancy` is updated on the same edge as the push/pop. A simultaneous push and pop leave it unchanged.
- Duplicate comparison uses queue and history contents as they were before the current edge.

## Configuration
- `PFQ_HISTORY_EN` defined: a HIST-entry history is compiled in. Each granted address is written at a round-robin pointer on its grant edge and takes part in duplicate detection from the next edge onward.
- Not defined: no history storage. Duplicates are detected only against queue entries and the in-flight `mem_addr`, so an address can be re-issued once its grant completes.

## Test plan
- Reset, then `in_addr`=13 with `in_valid` for one cycle and `mem_gnt`=1 → `mem_req`=1, `mem_addr`=13 one edge after capture; `mem_req`=0 after the grant; counters stay 0.
- `in_addr`=27, then 40 → no request issued, `filt_cnt`=2.
- Burst 4, 12, 4, 14 with `mem_gnt`=0 → `occupancy`=2 with one request in flight (`mem_addr`=4), `filt_cnt`=1; with `mem_gnt`=1, issue order is 4, 12, 14.
- `mem_gnt`=0, push DEPTH+2 distinct valid addresses → one in flight, `occupancy`=DEPTH, `drop_cnt`=1.
- Full queue, `mem_gnt`=1 and a new distinct candidate on the same edge → candidate accepted, `occupancy` unchanged, `drop_cnt` unchanged.
- History: with PFQ_HISTORY_EN, re-send 13 after its grant → `filt_cnt`+1 and no request. Without it, 13 is re-issued.
